// File: rtl/bm_fp_pkg.sv
// Shared fixed-point / binary64 definitions for the Box-Muller datapath.
// Used by both the U1 denormalizer and renormalizer.
package bm_fp_pkg;

   localparam int BIAS   = 1023;
   localparam int FW     = 105;
   localparam int VW     = 9;
   localparam int DW     = FW - VW;
   localparam int MANT_W = 52;
   localparam int EXP_W  = 11;
   localparam int LZ_W   = 7;

   typedef struct packed {
      logic              sign;
      logic [EXP_W-1:0]  exp;
      logic [MANT_W-1:0] frac;
   } fields_t;

endpackage

// File: rtl/u1_renorm_if.sv
// Push-only sample bus for the U1 renormalizer.
// Master drives the fixed-point sample, slave returns the double.
interface u1_renorm_if;
   import bm_fp_pkg::*;

   logic          pushin;
   logic [VW-1:0] v_in;
   logic [DW-1:0] delta_in;
   logic          pushout;
   logic [63:0]   U_out;

   modport master (
      output pushin, v_in, delta_in,
      input  pushout, U_out
   );

   modport slave (
      input  pushin, v_in, delta_in,
      output pushout, U_out
   );

endinterface

// File: rtl/lzc105.sv
// Combinational 105-bit leading-zero counter, binary-search tree.
// Padding with ones below the LSB caps the count at 105 for x==0.
module lzc105
   import bm_fp_pkg::*;
(
   input  logic [FW-1:0]   x,
   output logic [LZ_W-1:0] cnt,
   output logic            all_zero
);

   logic [127:0] y;
   logic [63:0]  y6;
   logic [31:0]  y5;
   logic [15:0]  y4;
   logic [7:0]   y3;
   logic [3:0]   y2;
   logic [1:0]   y1;

   assign y      = {x, {(128-FW){1'b1}}};
   assign cnt[6] = ~|y[127:64];
   assign y6     = cnt[6] ? y[63:0] : y[127:64];
   assign cnt[5] = ~|y6[63:32];
   assign y5     = cnt[5] ? y6[31:0] : y6[63:32];
   assign cnt[4] = ~|y5[31:16];
   assign y4     = cnt[4] ? y5[15:0] : y5[31:16];
   assign cnt[3] = ~|y4[15:8];
   assign y3     = cnt[3] ? y4[7:0] : y4[15:8];
   assign cnt[2] = ~|y3[7:4];
   assign y2     = cnt[2] ? y3[3:0] : y3[7:4];
   assign cnt[1] = ~|y2[3:2];
   assign y1     = cnt[1] ? y2[1:0] : y2[3:2];
   // y is never zero, so a clear top bit implies y1 == 2'b01
   assign cnt[0] = (y1 == 2'b01);

   assign all_zero = ~|x;

endmodule

// File: rtl/u1_renorm.sv
// Three-stage normalizer: 105-bit fraction in [0,1) to binary64,
// round-to-nearest-even, push-only valid flow.
module u1_renorm
   import bm_fp_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   u1_renorm_if.slave bus
);

   logic [FW-1:0]     x_in;
   logic [LZ_W-1:0]   lz_c;
   logic              z_c;

   logic              v1;
   logic [FW-1:0]     x1;
   logic [LZ_W-1:0]   lz1;
   logic              z1;

   logic [FW-1:0]     xs;
   logic [MANT_W-1:0] frac_c;
   logic              guard_c;
   logic              sticky_c;
   logic [EXP_W-1:0]  exp_c;

   logic              v2;
   logic [MANT_W-1:0] f2;
   logic              g2;
   logic              s2;
   logic [EXP_W-1:0]  e2;
   logic              z2;

   logic              rnd;
   logic [MANT_W:0]   sum;
   logic [EXP_W-1:0]  e_r;
   fields_t           res;

   logic              v3;
   logic [63:0]       u3;

   assign x_in = {bus.v_in, bus.delta_in};

   lzc105 u_lzc (
      .x        (x_in),
      .cnt      (lz_c),
      .all_zero (z_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v1  <= 1'b0;
         x1  <= '0;
         lz1 <= '0;
         z1  <= 1'b0;
      end else begin
         v1 <= bus.pushin;
         if (bus.pushin) begin
            x1  <= x_in;
            lz1 <= lz_c;
            z1  <= z_c;
         end
      end
   end

   // Shifting out the hidden one zero-fills short values, so
   // guard/sticky vanish naturally when the leading one is low.
   always_comb begin
      xs       = x1 << (lz1 + 7'd1);
      frac_c   = xs[FW-1 -: MANT_W];
      guard_c  = xs[FW-1-MANT_W];
      sticky_c = |xs[FW-2-MANT_W:0];
      exp_c    = EXP_W'(BIAS - 1) - EXP_W'(lz1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v2 <= 1'b0;
         f2 <= '0;
         g2 <= 1'b0;
         s2 <= 1'b0;
         e2 <= '0;
         z2 <= 1'b0;
      end else begin
         v2 <= v1;
         if (v1) begin
            f2 <= frac_c;
            g2 <= guard_c;
            s2 <= sticky_c;
            e2 <= exp_c;
            z2 <= z1;
         end
      end
   end

   // A mantissa carry-out leaves frac at zero and bumps the exponent.
   always_comb begin
      rnd = g2 & (s2 | f2[0]);
      sum = {1'b0, f2} + {{MANT_W{1'b0}}, rnd};
      e_r = e2 + {{(EXP_W-1){1'b0}}, sum[MANT_W]};
      res = '{sign: 1'b0, exp: e_r, frac: sum[MANT_W-1:0]};
      if (z2)
         res = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v3 <= 1'b0;
         u3 <= '0;
      end else begin
         v3 <= v2;
         if (v2)
            u3 <= res;
      end
   end

   assign bus.pushout = v3;
   assign bus.U_out   = u3;

endmodule

// File: tb/tb_u1_renorm.sv
// Scoreboard bench for u1_renorm: directed rounding cases, streaming
// with gaps, and asynchronous reset with samples in flight.
module tb_u1_renorm;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;

   logic [63:0] sb[$];
   logic [2:0]  pv;

   u1_renorm_if bus ();

   u1_renorm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Expected valid: pushin delayed three edges, cleared by reset.
   always @(posedge clk or posedge rst) begin
      if (rst)
         pv <= 3'b000;
      else
         pv <= {pv[1:0], bus.pushin};
   end

   function automatic logic [63:0] ref_model(input logic [104:0] x);
      int          p;
      logic [127:0] m;
      logic [127:0] rem;
      logic [127:0] half;
      logic [127:0] xw;
      logic [10:0]  e;
      if (x == '0)
         return 64'h0;
      p = 0;
      for (int i = 0; i < 105; i++)
         if (x[i]) p = i;
      xw = {23'b0, x};
      if (p >= 53) begin
         m    = xw >> (p - 52);
         rem  = xw & ((128'd1 << (p - 52)) - 128'd1);
         half = 128'd1 << (p - 53);
         if (rem > half || (rem == half && m[0]))
            m = m + 128'd1;
      end else begin
         m = xw << (52 - p);
      end
      if (m[53]) begin
         m = m >> 1;
         p = p + 1;
      end
      e = 11'(p + 918);
      return {1'b0, e, m[51:0]};
   endfunction

   function automatic logic [104:0] rnd_x();
      logic [127:0] r;
      r = {$urandom, $urandom, $urandom, $urandom};
      return 105'(r >> $urandom_range(23, 130));
   endfunction

   task automatic drive(input logic p, input logic [104:0] x,
                        input logic [63:0] e);
      @(negedge clk);
      bus.pushin   = p;
      bus.v_in     = x[104:96];
      bus.delta_in = x[95:0];
      if (p)
         sb.push_back(e);
   endtask

   task automatic push_x(input logic [104:0] x);
      drive(1'b1, x, ref_model(x));
   endtask

   always @(negedge clk) begin
      logic [63:0] exp_u;
      n_vec++;
      assert (bus.pushout === pv[2]) else begin
         n_bad++;
         $error("FAIL pushout got %b want %b", bus.pushout, pv[2]);
      end
      if (bus.pushout === 1'b1) begin
         n_vec++;
         assert (sb.size() > 0) else begin
            n_bad++;
            $error("FAIL sb_empty got pushout=1 want none pending");
         end
         if (sb.size() > 0) begin
            exp_u = sb.pop_front();
            n_vec++;
            assert (bus.U_out === exp_u) else begin
               n_bad++;
               $error("FAIL U_out got %h want %h", bus.U_out, exp_u);
            end
         end
      end
   end

   initial begin
      logic [104:0] x;
      n_vec        = 0;
      n_bad        = 0;
      bus.pushin   = 1'b0;
      bus.v_in     = '0;
      bus.delta_in = '0;
      rst          = 1'b0;
      #1 rst = 1'b1;
      #2;
      n_vec++;
      assert (bus.pushout === 1'b0 && bus.U_out === 64'h0) else begin
         n_bad++;
         $error("FAIL reset_state got %b/%h want 0/0",
                bus.pushout, bus.U_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single sample, then idle to show the isolated latency.
      drive(1'b1, 105'd1 << 104, 64'h3FE0000000000000);
      drive(1'b0, '0, '0);
      repeat (4) @(negedge clk);

      drive(1'b1, 105'd1, 64'h3960000000000000);
      drive(1'b1, 105'd0, 64'h0000000000000000);
      drive(1'b1, (105'd1 << 104) | (105'd1 << 51),
            64'h3FE0000000000000);
      drive(1'b1, (105'd1 << 104) | (105'd1 << 52) | (105'd1 << 51),
            64'h3FE0000000000002);
      drive(1'b1, (105'd1 << 104) | (105'd1 << 51) | 105'd1,
            64'h3FE0000000000001);
      drive(1'b1, {105{1'b1}}, 64'h3FF0000000000000);
      drive(1'b1, 105'd1 << 51, ref_model(105'd1 << 51));
      drive(1'b1, 105'h1F << 48, ref_model(105'h1F << 48));
      drive(1'b0, '0, '0);

      for (int i = 0; i < 200; i++)
         push_x(rnd_x());
      for (int i = 0; i < 150; i++) begin
         x = rnd_x();
         if ($urandom_range(0, 2) != 0)
            push_x(x);
         else
            drive(1'b0, x, '0);
      end
      drive(1'b0, '0, '0);
      repeat (5) @(negedge clk);

      // Three samples in flight, then asynchronous reset mid-cycle.
      push_x(105'd12345);
      push_x(105'd1 << 100);
      push_x({105{1'b1}} >> 7);
      @(posedge clk);
      #2;
      bus.pushin = 1'b0;
      rst        = 1'b1;
      sb.delete();
      #1;
      n_vec++;
      assert (bus.pushout === 1'b0 && bus.U_out === 64'h0) else begin
         n_bad++;
         $error("FAIL mid_reset got %b/%h want 0/0",
                bus.pushout, bus.U_out);
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      push_x((105'd1 << 90) | 105'd7);
      drive(1'b0, '0, '0);
      repeat (6) @(negedge clk);

      n_vec++;
      assert (sb.size() == 0) else begin
         n_bad++;
         $error("FAIL drain got %0d pending want 0", sb.size());
      end

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end

endmodule
